var_iter_sequencer: RTL and testbench
=====================================

// Module: var_iter_sequencer
// PURPOSE
//  Variable-node side sequencer for the LDPC decoder.
//  - Launches each check-node phase with a check_start pulse.
//  - Waits for check_done and the syndrome result from the check side.
//  - Steps the variable-node update across n column slots, then counts full decoding iterations.
//  - Stops on syndrome satisfied (success) or on MAX_ITER iterations (failure).
// PARAMETERS
//  log2n     3   width of var_iter_count
//  n         8   variable-node slots per VAR phase (n <= 2**log2n)
//  log2iter  4   width of iter_count
//  MAX_ITER  10  decoding iterations before giving up (1 <= MAX_ITER < 2**log2iter)
// PORTS
//  clk             in   1         clock; all logic on rising edge
//  rst             in   1         synchronous, active-high reset
//  start           in   1         begin a decode; sampled only in IDLE
//  check_done      in   1         1-cycle pulse: check-node phase finished
//  syndrome_ok     in   1         all parity checks satisfied; valid only with check_done
//  check_start     out  1         1-cycle pulse launching a check-node phase
//  var_en          out  1         variable-node update enable for the current slot
//  var_iter_count  out  log2n     current variable-node slot, 0..n-1
//  iter_count      out  log2iter  completed decoding iterations
//  state           out  2         0=IDLE 1=CHECK 2=VAR 3=DONE
//  busy            out  1         high whenever state != IDLE
//  done            out  1         1-cycle pulse: decode finished
//  success         out  1         decode converged; valid from done until the next accepted start
// BEHAVIOUR
//  - All outputs are registered. In the cycle after a rst edge, every output is 0 and state=IDLE.
//  - Reset applies on any clk edge where rst=1, including mid-decode.
//    - It aborts the decode.
//    - No done pulse is produced.
//  - IDLE:
//    - start=1 at edge t -> at t+1: state=CHECK, check_start=1 for exactly one cycle.
//    - The same edge clears iter_count and success.
//  - CHECK:
//    - var_en=0. Hold until check_done=1; start is ignored.
//    - check_done with syndrome_ok=1 -> DONE, success=1.
//    - check_done with syndrome_ok=0 -> VAR, var_iter_count=0, var_en=1.
//  - VAR:
//    - var_en=1 for exactly n consecutive cycles; var_iter_count runs 0,1,..,n-1.
//    - At the edge that ends slot n-1, iter_count increments. If the new value == MAX_ITER -> DONE, success=0.
//    - Otherwise -> CHECK with check_start=1 for one cycle, and var_iter_count returns to 0.
//    - check_done and syndrome_ok are ignored in VAR.
//  - DONE:
//    - Lasts one cycle with done=1, then IDLE.
//    - iter_count and success hold until the next accepted start.
//    - A start asserted during DONE is ignored; it must be reasserted in IDLE.
//  - check_done outside CHECK is ignored.
//  - check_done in the same cycle as check_start is legal; it is accepted.
//  - iter_count never exceeds MAX_ITER. var_iter_count wraps only via the VAR->CHECK transition.
//  - busy = (state != IDLE), registered together with state.
//  - Per iteration, minimum cycles from check_start to the next check_start = 1 + n (zero-latency check_done).
// TESTING
//  1. Reset: hold rst 2 cycles mid-VAR.
//     -> next cycle state=0, var_en=0, iter_count=0, done=0, check_start=0.
//  2. Immediate convergence: start; check_done=1, syndrome_ok=1 on first CHECK.
//     -> done pulse, success=1, iter_count=0, var_en never high.
//  3. Converge on iteration 3: syndrome_ok=0 for the first 3 check_done, then 1.
//     -> 3 VAR phases of 8 var_en cycles each with counts 0..7, then done, success=1, iter_count=3.
//  4. Failure: syndrome_ok always 0, MAX_ITER=10.
//     -> exactly 10 check_start pulses, done after the 10th VAR phase, success=0, iter_count=10.
//  5. Protocol noise:
//     - check_done pulses during VAR and IDLE -> no state change.
//     - start during CHECK and DONE -> ignored.
//     - start in IDLE -> check_start the next cycle.
//  6. Back-to-back decodes: start in the cycle after done.
//     -> iter_count and success clear and check_start pulses. Then assert rst mid-CHECK -> IDLE, no done pulse.

Source files
------------

// File: rtl/var_iter_sequencer.sv
// Variable-node side sequencer for the LDPC decoder: alternates check-node phases
// with n-slot variable-node sweeps until the syndrome clears or MAX_ITER is reached.
module var_iter_sequencer #(
    parameter int log2n    = 3,
    parameter int n        = 8,
    parameter int log2iter = 4,
    parameter int MAX_ITER = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                check_done,
    input  logic                syndrome_ok,
    output logic                check_start,
    output logic                var_en,
    output logic [log2n-1:0]    var_iter_count,
    output logic [log2iter-1:0] iter_count,
    output logic [1:0]          state,
    output logic                busy,
    output logic                done,
    output logic                success
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        VAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [log2n-1:0]    LAST_SLOT  = log2n'(n - 1);
    localparam logic [log2iter-1:0] ITER_LIMIT = log2iter'(MAX_ITER);

    state_t                state_q;
    state_t                state_d;
    logic                  check_start_d;
    logic                  var_en_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  success_d;
    logic [log2n-1:0]      slot_d;
    logic [log2iter-1:0]   iter_d;
    logic [log2iter-1:0]   iter_inc;

    // Every output is computed one cycle ahead here so that all ports come straight from flops.
    always_comb begin
        iter_inc      = iter_count + log2iter'(1);
        state_d       = state_q;
        check_start_d = 1'b0;
        var_en_d      = 1'b0;
        done_d        = 1'b0;
        slot_d        = var_iter_count;
        iter_d        = iter_count;
        success_d     = success;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = CHECK;
                    check_start_d = 1'b1;
                    iter_d        = '0;
                    success_d     = 1'b0;
                end
            end
            CHECK: begin
                if (check_done) begin
                    if (syndrome_ok) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        success_d = 1'b1;
                    end else begin
                        state_d  = VAR;
                        var_en_d = 1'b1;
                        slot_d   = '0;
                    end
                end
            end
            VAR: begin
                // The last slot closes an iteration; only a return to CHECK rewinds the slot counter.
                if (var_iter_count == LAST_SLOT) begin
                    iter_d = iter_inc;
                    if (iter_inc == ITER_LIMIT) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        success_d = 1'b0;
                    end else begin
                        state_d       = CHECK;
                        check_start_d = 1'b1;
                        slot_d        = '0;
                    end
                end else begin
                    slot_d   = var_iter_count + log2n'(1);
                    var_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            check_start    <= 1'b0;
            var_en         <= 1'b0;
            var_iter_count <= '0;
            iter_count     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            success        <= 1'b0;
        end else begin
            state_q        <= state_d;
            check_start    <= check_start_d;
            var_en         <= var_en_d;
            var_iter_count <= slot_d;
            iter_count     <= iter_d;
            busy           <= busy_d;
            done           <= done_d;
            success        <= success_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_var_iter_sequencer.sv
// Self-checking bench for var_iter_sequencer: a directed vector table, then whole decodes
// checked against a per-decode outcome model (iterations, pulse counts, slot order).
module tb_var_iter_sequencer;

    localparam int LOG2N    = 3;
    localparam int N        = 8;
    localparam int LOG2ITER = 4;
    localparam int MAX_ITER = 10;

    logic                clk;
    logic                rst;
    logic                start;
    logic                check_done;
    logic                syndrome_ok;
    logic                check_start;
    logic                var_en;
    logic [LOG2N-1:0]    var_iter_count;
    logic [LOG2ITER-1:0] iter_count;
    logic [1:0]          state;
    logic                busy;
    logic                done;
    logic                success;

    int vectors;
    int miscompares;
    int cycle;
    int cs_seen;
    int var_seen;
    int done_seen;
    int var_run;
    int last_cs;
    int cs_interval;

    typedef struct {
        int rst; int start; int cd; int ok;
        int st; int cs; int ve; int cnt; int it; int busy; int dn; int sc;
    } vec_t;

    vec_t tbl[16];

    var_iter_sequencer #(
        .log2n(LOG2N), .n(N), .log2iter(LOG2ITER), .MAX_ITER(MAX_ITER)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .check_done(check_done),
        .syndrome_ok(syndrome_ok), .check_start(check_start), .var_en(var_en),
        .var_iter_count(var_iter_count), .iter_count(iter_count), .state(state),
        .busy(busy), .done(done), .success(success)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, and the running
    // protocol counters (pulse counts, slot order, VAR run length) are updated.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        if (check_start) begin
            cs_seen++;
            cs_interval = cycle - last_cs;
            last_cs     = cycle;
        end
        if (done) done_seen++;
        if (rst) begin
            var_run = 0;
        end else if (var_en) begin
            checkOutput("slot_order", var_iter_count, var_run);
            var_run++;
            var_seen++;
        end else if (var_run != 0) begin
            checkOutput("var_run_len", var_run, N);
            var_run = 0;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst         = 1'(v.rst);
        start       = 1'(v.start);
        check_done  = 1'(v.cd);
        syndrome_ok = 1'(v.ok);
        tick();
    endtask

    // Drives one full decode. The check side answers each check_start after a delay,
    // reporting syndrome_ok only on the answer numbered first_ok (0-based).
    task automatic run_decode(input int first_ok, input bit noise, input bit rand_delay);
        int  exp_iter, exp_cs, phase, budget, d, cs0, var0, done0;
        bit  exp_succ;
        exp_succ = (first_ok < MAX_ITER);
        exp_iter = exp_succ ? first_ok : MAX_ITER;
        exp_cs   = exp_succ ? first_ok + 1 : MAX_ITER;
        cs0   = cs_seen;
        var0  = var_seen;
        done0 = done_seen;

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_state", state, 1);
        checkOutput("start_check_start", check_start, 1);
        checkOutput("start_iter_clear", iter_count, 0);
        checkOutput("start_success_clear", success, 0);

        phase  = 0;
        budget = 0;
        while (state != 2'd3 && budget < 3000) begin
            budget++;
            if (check_start) begin
                if (!rand_delay && phase > 0) checkOutput("check_start_interval", cs_interval, 1 + N);
                d = rand_delay ? int'($urandom_range(0, 3)) : 0;
                for (int i = 0; i < d; i++) begin
                    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    tick();
                end
                start       = 1'b0;
                check_done  = 1'b1;
                syndrome_ok = (phase == first_ok);
                phase++;
                tick();
                check_done  = 1'b0;
                syndrome_ok = 1'b0;
            end else begin
                if (noise && state == 2'd2) begin
                    check_done  = 1'($urandom_range(0, 1));
                    syndrome_ok = 1'($urandom_range(0, 1));
                    start       = 1'($urandom_range(0, 1));
                end
                tick();
                check_done  = 1'b0;
                syndrome_ok = 1'b0;
                start       = 1'b0;
            end
        end
        if (state != 2'd3) checkOutput("reached_done", 0, 1);

        checkOutput("done_pulse", done, 1);
        checkOutput("done_success", success, exp_succ);
        checkOutput("done_iter", iter_count, exp_iter);
        checkOutput("done_var_en", var_en, 0);

        start = noise;
        tick();
        start = 1'b0;
        checkOutput("after_done_state", state, 0);
        checkOutput("after_done_pulse", done, 0);
        checkOutput("after_done_busy", busy, 0);
        checkOutput("hold_iter", iter_count, exp_iter);
        checkOutput("hold_success", success, exp_succ);
        checkOutput("check_start_count", cs_seen - cs0, exp_cs);
        checkOutput("var_en_cycles", var_seen - var0, exp_iter * N);
        checkOutput("done_count", done_seen - done0, 1);
    endtask

    initial begin
        int d0;
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        cs_seen     = 0;
        var_seen    = 0;
        done_seen   = 0;
        var_run     = 0;
        last_cs     = 0;
        cs_interval = 0;
        rst         = 1'b1;
        start       = 1'b0;
        check_done  = 1'b0;
        syndrome_ok = 1'b0;

        //          rst st cd ok | st cs ve cnt it busy dn sc
        tbl[0]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 1,   3, 0, 0, 0, 0, 1, 1, 1};
        tbl[6]  = '{0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 1, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 0,   2, 0, 1, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 1,   2, 0, 1, 1, 0, 1, 0, 0};
        tbl[12] = '{0, 1, 0, 0,   2, 0, 1, 2, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("row%0d_state", i), state, tbl[i].st);
            checkOutput($sformatf("row%0d_check_start", i), check_start, tbl[i].cs);
            checkOutput($sformatf("row%0d_var_en", i), var_en, tbl[i].ve);
            checkOutput($sformatf("row%0d_var_iter_count", i), var_iter_count, tbl[i].cnt);
            checkOutput($sformatf("row%0d_iter_count", i), iter_count, tbl[i].it);
            checkOutput($sformatf("row%0d_busy", i), busy, tbl[i].busy);
            checkOutput($sformatf("row%0d_done", i), done, tbl[i].dn);
            checkOutput($sformatf("row%0d_success", i), success, tbl[i].sc);
        end

        $display("[TB] immediate convergence, converge on iteration 3, failure at MAX_ITER");
        run_decode(0, 1'b0, 1'b0);
        run_decode(3, 1'b0, 1'b0);
        run_decode(MAX_ITER + 5, 1'b0, 1'b0);
        run_decode(MAX_ITER - 1, 1'b0, 1'b0);

        $display("[TB] back-to-back decodes, then reset mid-CHECK");
        run_decode(1, 1'b1, 1'b0);
        run_decode(2, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("mid_check_state", state, 1);
        d0  = done_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_check_state", state, 0);
        checkOutput("rst_check_busy", busy, 0);
        checkOutput("rst_check_done", done, 0);
        checkOutput("rst_check_iter", iter_count, 0);
        checkOutput("rst_check_start", check_start, 0);
        repeat (3) tick();
        checkOutput("rst_no_done_pulse", done_seen - d0, 0);
        checkOutput("rst_stays_idle", state, 0);

        $display("[TB] randomized decodes with protocol noise");
        for (int k = 0; k < 20; k++) begin
            run_decode(int'($urandom_range(0, MAX_ITER + 2)), 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
